dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage 16-bit pipelined core; it is the slave end of the core's dmemaddr/dmemwdata/dmemwrite/dmemread/dmemrdata interface.
- Contains a word RAM plus a small memory-mapped I/O page: LED register, synchronized switches, cycle counter and sticky status.
- Read data is returned combinationally in the same cycle, because the core samples dmemrdata into MEM/WB at the next rising edge.
- Writes commit on the rising clock edge.

Parameters:
- ADDR_BITS, 7, RAM word-index width; depth = 2^ADDR_BITS words of 16 bits.
- IO_PAGE, 8'hFF, value of dmemaddr[15:8] that selects the MMIO page.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- dmemaddr  in  16  byte address from the core's EX/MEM stage.
- dmemwdata  in  16  store data.
- dmemwrite  in  1  store enable.
- dmemread  in  1  load enable.
- dmemrdata  out  16  load data, combinational.
- switches  in  8  asynchronous board switches.
- leds  out  16  LED register contents.
- err  out  1  OR of the sticky status bits.

Behaviour:
- Reset is synchronous and active-high on clock.
  - leds = 0, cycle counter = 0, status = 0, switch synchronizer flops = 0, err = 0.
  - RAM contents are not cleared.
- Decode:
  - io = (dmemaddr[15:8] == IO_PAGE); otherwise the access goes to RAM.
  - RAM word index = dmemaddr[ADDR_BITS:1]; higher address bits are ignored, so RAM aliases.
  - dmemaddr[0] is ignored for data selection.
- Read path (combinational, zero latency):
  - dmemrdata = selected word when dmemread = 1, else 16'h0000.
- Write path: when dmemwrite = 1 the selected word or register updates at the rising edge. A read in the same cycle returns the pre-write value.
- MMIO map (byte address; writes to read-only locations are ignored):
  - FF00 LED: R/W 16 bits, drives leds.
  - FF02 SW: read-only, {8'h00, sw_sync}. sw_sync passes through a 2-flop synchronizer, so a switch change is visible on the third rising edge after it occurs.
  - FF04 CYC: free-running 16-bit counter, +1 every cycle, wraps FFFF to 0000. A write of any data loads 0 at that edge, overriding the increment. A read returns the current value.
  - FF06 STAT: bit0 = rw_conflict, bit1 = misaligned, bits 15:2 read as 0. Write-1-to-clear per bit.
  - All other MMIO offsets: read 0, writes ignored.
- Sticky status:
  - rw_conflict sets at any edge where dmemread and dmemwrite are both 1. The write is still performed.
  - misaligned sets at any edge where (dmemread | dmemwrite) and dmemaddr[0] = 1. The access is still performed on the even word.
  - Set beats clear in the same cycle: a STAT write that clears a bit while a new error event occurs leaves that bit set.
- err = |STAT, registered (follows the STAT flops).

Optional Feature:
- Macro DMEM_STORE_CNT_EN.
- When defined:
  - Adds FF08 STCNT, a 16-bit count of RAM stores: +1 per edge with dmemwrite = 1 and io = 0.
  - Saturates at FFFF.
  - A write to FF08 clears it.
  - Reset value is 0.
- When undefined: FF08 reads 0 and no counter flops exist.

Test Plan:
- Reset, then write 16'hBEEF to 0x0010, then read 0x0010 next cycle -> dmemrdata = BEEF. With dmemread = 0 -> dmemrdata = 0000.
- Same-cycle read+write at 0x0020 (old value 1111, new 2222) -> dmemrdata = 1111 that cycle, 2222 the next cycle; STAT = 0001 and err = 1 after the edge. Write FF06 with 0001 -> STAT = 0000, err = 0.
- Write FF00 with A5A5 -> leds = A5A5 after the edge. Set switches = 8'h3C -> read FF02 returns 003C from the third edge, 0000 before.
- Let the counter run to FFFF -> next value 0000. Write FF04 -> reads 0000 on the following cycle, then 0001.
- Read 0x0011 after writing 0x0010 = 1234 -> dmemrdata = 1234, STAT bit1 = 1. Reset asserted mid-run -> leds, CYC, STAT, err = 0 on the next edge.
- With DMEM_STORE_CNT_EN defined: 3 RAM stores plus 1 FF00 store -> FF08 reads 0003. Without the macro: FF08 reads 0000.

Source files
------------

// File: rtl/dmem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Data-memory bus between the pipelined core (master) and the
//               data-memory responder (slave). Read data is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;

    modport master (
        output dmemaddr,
        output dmemwdata,
        output dmemwrite,
        output dmemread,
        input  dmemrdata
    );

    modport slave (
        input  dmemaddr,
        input  dmemwdata,
        input  dmemwrite,
        input  dmemread,
        output dmemrdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory slave for the 16-bit pipelined core. Word RAM plus
//               an MMIO page (LED, synchronized switches, cycle counter,
//               sticky status). Zero-latency read, writes commit on the edge.
//               Optional macro DMEM_STORE_CNT_EN adds a saturating RAM-store
//               counter at FF08.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          ADDR_BITS = 7,
    parameter logic [7:0]  IO_PAGE   = 8'hFF
) (
    input  logic                clock,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    input  logic [7:0]          switches,
    output logic [15:0]         leds,
    output logic                err
);

    localparam int          c_DEPTH     = 1 << ADDR_BITS;
    // MMIO register offsets, in 16-bit words within the IO page
    localparam logic [6:0]  c_OFF_LED   = 7'd0;
    localparam logic [6:0]  c_OFF_SW    = 7'd1;
    localparam logic [6:0]  c_OFF_CYC   = 7'd2;
    localparam logic [6:0]  c_OFF_STAT  = 7'd3;
`ifdef DMEM_STORE_CNT_EN
    localparam logic [6:0]  c_OFF_STCNT = 7'd4;
`endif

    logic [15:0]          r_mem [c_DEPTH];
    logic [15:0]          r_leds;
    logic [7:0]           r_sw_meta;
    logic [7:0]           r_sw_sync;
    logic [15:0]          r_cyc;
    logic [1:0]           r_stat;
    logic                 r_err;
`ifdef DMEM_STORE_CNT_EN
    logic [15:0]          r_stcnt;
`endif

    logic                 w_io;
    logic [6:0]           w_off;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_wr_io;
    logic                 w_wr_ram;
    logic                 w_evt_rw;
    logic                 w_evt_mis;
    logic [1:0]           w_stat_clr;
    logic [1:0]           w_stat_nxt;
    logic [15:0]          w_rdata;

    // Address decode: the page byte selects MMIO, bit 0 never selects data
    assign w_io      = (bus.dmemaddr[15:8] == IO_PAGE);
    assign w_off     = bus.dmemaddr[7:1];
    assign w_idx     = bus.dmemaddr[ADDR_BITS:1];
    assign w_wr_io   = bus.dmemwrite && w_io;
    assign w_wr_ram  = bus.dmemwrite && !w_io;

    // Error events are flagged but the access itself is still carried out
    assign w_evt_rw  = bus.dmemread && bus.dmemwrite;
    assign w_evt_mis = (bus.dmemread || bus.dmemwrite) && bus.dmemaddr[0];

    // Status next state: write-1-to-clear, a new event in the same cycle wins
    always_comb begin
        w_stat_clr = 2'b00;
        if (w_wr_io && (w_off == c_OFF_STAT)) begin
            w_stat_clr = bus.dmemwdata[1:0];
        end
        w_stat_nxt = (r_stat & ~w_stat_clr) | {w_evt_mis, w_evt_rw};
    end

    // RAM word write; contents survive reset
    always_ff @(posedge clock) begin
        if (w_wr_ram) begin
            r_mem[w_idx] <= bus.dmemwdata;
        end
    end

    // MMIO register file, switch synchronizer and sticky status
    always_ff @(posedge clock) begin
        if (reset) begin
            r_leds    <= 16'h0000;
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
            r_cyc     <= 16'h0000;
            r_stat    <= 2'b00;
            r_err     <= 1'b0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
            if (w_wr_io && (w_off == c_OFF_LED)) begin
                r_leds <= bus.dmemwdata;
            end
            if (w_wr_io && (w_off == c_OFF_CYC)) begin
                r_cyc <= 16'h0000;
            end else begin
                r_cyc <= r_cyc + 16'd1;
            end
            r_stat <= w_stat_nxt;
            r_err  <= |w_stat_nxt;
        end
    end

`ifdef DMEM_STORE_CNT_EN
    // Saturating count of RAM stores; any write to its address clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stcnt <= 16'h0000;
        end else if (w_wr_io && (w_off == c_OFF_STCNT)) begin
            r_stcnt <= 16'h0000;
        end else if (w_wr_ram && (r_stcnt != 16'hFFFF)) begin
            r_stcnt <= r_stcnt + 16'd1;
        end
    end
`endif

    // Zero-latency read mux; returns pre-write state during a store
    always_comb begin
        w_rdata = 16'h0000;
        if (bus.dmemread) begin
            if (w_io) begin
                case (w_off)
                    c_OFF_LED:   w_rdata = r_leds;
                    c_OFF_SW:    w_rdata = {8'h00, r_sw_sync};
                    c_OFF_CYC:   w_rdata = r_cyc;
                    c_OFF_STAT:  w_rdata = {14'h0000, r_stat};
`ifdef DMEM_STORE_CNT_EN
                    c_OFF_STCNT: w_rdata = r_stcnt;
`endif
                    default:     w_rdata = 16'h0000;
                endcase
            end else begin
                w_rdata = r_mem[w_idx];
            end
        end
    end

    assign bus.dmemrdata = w_rdata;
    assign leds          = r_leds;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder with a reference model
//               of the memory map kept in plain arrays and byte addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [7:0]  switches;
    logic [15:0] leds;
    logic        err;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_BITS (7),
        .IO_PAGE   (8'hFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .switches (switches),
        .leds     (leds),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] mmem [128];
    logic [15:0] m_leds;
    logic [15:0] m_cyc;
    logic [1:0]  m_stat;
    logic [15:0] m_stcnt;
    logic [7:0]  m_sw1;
    logic [7:0]  m_sw2;

    function automatic logic [15:0] model_read(input logic [15:0] a, input logic re);
        logic [15:0] r;
        r = 16'h0000;
        if (re) begin
            if (a[15:8] == 8'hFF) begin
                case (a & 16'hFFFE)
                    16'hFF00: r = m_leds;
                    16'hFF02: r = {8'h00, m_sw2};
                    16'hFF04: r = m_cyc;
                    16'hFF06: r = {14'h0000, m_stat};
`ifdef DMEM_STORE_CNT_EN
                    16'hFF08: r = m_stcnt;
`endif
                    default:  r = 16'h0000;
                endcase
            end else begin
                r = mmem[(a >> 1) % 128];
            end
        end
        return r;
    endfunction

    task automatic model_commit(input logic [15:0] a, input logic [15:0] wd,
                                input logic we, input logic re);
        logic [15:0] ea;
        logic        io;
        logic [1:0]  s;
        ea = a & 16'hFFFE;
        io = (a[15:8] == 8'hFF);
        s  = m_stat;
        if (we && io && ea == 16'hFF06) s = s & ~wd[1:0];
        if (we && re) s[0] = 1'b1;
        if ((we || re) && a[0]) s[1] = 1'b1;
        m_stat = s;
        if (we && io && ea == 16'hFF04) m_cyc = 16'h0000;
        else                            m_cyc = m_cyc + 16'd1;
        if (we && io && ea == 16'hFF00) m_leds = wd;
`ifdef DMEM_STORE_CNT_EN
        if (we && io && ea == 16'hFF08)              m_stcnt = 16'h0000;
        else if (we && !io && m_stcnt != 16'hFFFF)   m_stcnt = m_stcnt + 16'd1;
`endif
        if (we && !io) mmem[(a >> 1) % 128] = wd;
        m_sw2 = m_sw1;
        m_sw1 = switches;
    endtask

    // One bus cycle: drive, sample read data mid-cycle, advance the model at the edge
    task automatic step(input logic [15:0] a, input logic [15:0] wd,
                        input logic we, input logic re,
                        output logic [15:0] obs, output logic [15:0] exp);
        bus.dmemaddr  = a;
        bus.dmemwdata = wd;
        bus.dmemwrite = we;
        bus.dmemread  = re;
        @(negedge clock);
        obs = bus.dmemrdata;
        exp = model_read(a, re);
        @(posedge clock);
        model_commit(a, wd, we, re);
        #1;
        bus.dmemwrite = 1'b0;
        bus.dmemread  = 1'b0;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.dmemwrite = 1'b0;
        bus.dmemread  = 1'b0;
        @(posedge clock);
        m_leds = 16'h0000; m_cyc = 16'h0000; m_stat = 2'b00;
        m_stcnt = 16'h0000; m_sw1 = 8'h00; m_sw2 = 8'h00;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] o, e;
        apply_reset();
        n_cmp++; if (leds !== 16'h0000) begin n_bad++; $display("FAIL reset_leds: got %h want 0000", leds); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        step(16'hFF04, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL reset_cyc: got %h want 0000", o); end
        step(16'hFF06, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL reset_stat: got %h want 0000", o); end
    endtask

    task automatic test_ram();
        logic [15:0] o, e;
        step(16'h0010, 16'hBEEF, 1'b1, 1'b0, o, e);
        step(16'h0010, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'hBEEF) begin n_bad++; $display("FAIL ram_read: got %h want BEEF", o); end
        step(16'h0010, 16'h0000, 1'b0, 1'b0, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL ram_noread: got %h want 0000", o); end
        step(16'h0110, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'hBEEF) begin n_bad++; $display("FAIL ram_alias: got %h want BEEF", o); end
    endtask

    task automatic test_conflict();
        logic [15:0] o, e;
        step(16'h0020, 16'h1111, 1'b1, 1'b0, o, e);
        step(16'h0020, 16'h2222, 1'b1, 1'b1, o, e);
        n_cmp++; if (o !== 16'h1111) begin n_bad++; $display("FAIL rw_old: got %h want 1111", o); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rw_err: got %b want 1", err); end
        step(16'h0020, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h2222) begin n_bad++; $display("FAIL rw_new: got %h want 2222", o); end
        step(16'hFF06, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0001) begin n_bad++; $display("FAIL rw_stat: got %h want 0001", o); end
        step(16'hFF06, 16'h0001, 1'b1, 1'b0, o, e);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rw_clr_err: got %b want 0", err); end
        step(16'hFF06, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL rw_clr_stat: got %h want 0000", o); end
    endtask

    task automatic test_leds_switches();
        logic [15:0] o, e;
        step(16'hFF00, 16'hA5A5, 1'b1, 1'b0, o, e);
        n_cmp++; if (leds !== 16'hA5A5) begin n_bad++; $display("FAIL leds: got %h want A5A5", leds); end
        switches = 8'h3C;
        step(16'hFF02, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL sw_edge1: got %h want 0000", o); end
        step(16'hFF02, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL sw_edge2: got %h want 0000", o); end
        step(16'hFF02, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h003C) begin n_bad++; $display("FAIL sw_edge3: got %h want 003C", o); end
        step(16'hFF02, 16'hFFFF, 1'b1, 1'b1, o, e);
        step(16'hFF02, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h003C) begin n_bad++; $display("FAIL sw_readonly: got %h want 003C", o); end
        step(16'hFF06, 16'h0003, 1'b1, 1'b0, o, e);
    endtask

    task automatic test_counter();
        logic [15:0] o, e;
        int guard;
        guard = 0;
        while (m_cyc != 16'hFFFF && guard < 70000) begin
            step(16'h0000, 16'h0, 1'b0, 1'b0, o, e);
            guard++;
        end
        n_cmp++; if (guard >= 70000) begin n_bad++; $display("FAIL cyc_timeout: got %0d cycles want <70000", guard); end
        step(16'hFF04, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'hFFFF) begin n_bad++; $display("FAIL cyc_max: got %h want FFFF", o); end
        step(16'hFF04, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL cyc_wrap: got %h want 0000", o); end
        step(16'h0000, 16'h0, 1'b0, 1'b0, o, e);
        step(16'hFF04, 16'h1234, 1'b1, 1'b0, o, e);
        step(16'hFF04, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL cyc_load0: got %h want 0000", o); end
        step(16'hFF04, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0001) begin n_bad++; $display("FAIL cyc_after_load: got %h want 0001", o); end
    endtask

    task automatic test_misaligned();
        logic [15:0] o, e;
        step(16'h0010, 16'h1234, 1'b1, 1'b0, o, e);
        step(16'h0011, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h1234) begin n_bad++; $display("FAIL mis_read: got %h want 1234", o); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", err); end
        step(16'hFF06, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0002) begin n_bad++; $display("FAIL mis_stat: got %h want 0002", o); end
        // misaligned clear of STAT: the new event must win over the clear
        step(16'hFF07, 16'h0002, 1'b1, 1'b0, o, e);
        step(16'hFF06, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0002) begin n_bad++; $display("FAIL set_beats_clr: got %h want 0002", o); end
        step(16'hFF06, 16'h0002, 1'b1, 1'b0, o, e);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mis_clr: got %b want 0", err); end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] o, e;
        step(16'hFF00, 16'h1357, 1'b1, 1'b0, o, e);
        step(16'h0011, 16'h0000, 1'b0, 1'b1, o, e);
        apply_reset();
        n_cmp++; if (leds !== 16'h0000) begin n_bad++; $display("FAIL mid_leds: got %h want 0000", leds); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", err); end
        step(16'hFF04, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL mid_cyc: got %h want 0000", o); end
        step(16'hFF06, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL mid_stat: got %h want 0000", o); end
        step(16'h0010, 16'h0, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h1234) begin n_bad++; $display("FAIL mid_ram_kept: got %h want 1234", o); end
    endtask

    task automatic test_store_count();
        logic [15:0] o, e;
        logic [15:0] want;
        apply_reset();
        step(16'h0030, 16'h0001, 1'b1, 1'b0, o, e);
        step(16'h0032, 16'h0002, 1'b1, 1'b0, o, e);
        step(16'h0034, 16'h0003, 1'b1, 1'b0, o, e);
        step(16'hFF00, 16'h0004, 1'b1, 1'b0, o, e);
        step(16'hFF08, 16'h0000, 1'b0, 1'b1, o, e);
`ifdef DMEM_STORE_CNT_EN
        want = 16'h0003;
`else
        want = 16'h0000;
`endif
        n_cmp++; if (o !== want) begin n_bad++; $display("FAIL stcnt: got %h want %h", o, want); end
        step(16'hFF08, 16'hFFFF, 1'b1, 1'b0, o, e);
        step(16'hFF08, 16'h0000, 1'b0, 1'b1, o, e);
        n_cmp++; if (o !== 16'h0000) begin n_bad++; $display("FAIL stcnt_clr: got %h want 0000", o); end
    endtask

    task automatic test_random();
        logic [15:0] o, e, a, wd;
        logic        we, re;
        for (int i = 0; i < 128; i++) begin
            step(16'(i * 2), 16'($urandom), 1'b1, 1'b0, o, e);
        end
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = 16'hFF00 | 16'($urandom_range(0, 15));
            end else begin
                a = 16'($urandom);
                if (a[15:8] == 8'hFF) a[15:8] = 8'h00;
            end
            wd = 16'($urandom);
            we = ($urandom_range(0, 2) == 0);
            re = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) switches = 8'($urandom);
            step(a, wd, we, re, o, e);
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rand_rd[%0d] a=%h: got %h want %h", i, a, o, e); end
            n_cmp++; if (leds !== m_leds) begin n_bad++; $display("FAIL rand_leds[%0d]: got %h want %h", i, leds, m_leds); end
            n_cmp++; if (err !== (|m_stat)) begin n_bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, err, |m_stat); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        switches      = 8'h00;
        bus.dmemaddr  = 16'h0000;
        bus.dmemwdata = 16'h0000;
        bus.dmemwrite = 1'b0;
        bus.dmemread  = 1'b0;
        for (int i = 0; i < 128; i++) mmem[i] = 16'h0000;
        m_leds = 16'h0; m_cyc = 16'h0; m_stat = 2'b00; m_stcnt = 16'h0; m_sw1 = 8'h0; m_sw2 = 8'h0;
        @(posedge clock);
        #1;
        test_reset();
        test_ram();
        test_conflict();
        test_leds_switches();
        test_counter();
        test_misaligned();
        test_reset_midrun();
        test_store_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
